mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 20 ++
 rtl/mem_arbiter_rr_arbiter2.sv | 51 +++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared constants and types for the two-port memory arbiter.
//   NUM_PORTS : number of requesting ports (0 = fetch, 1 = data)
//   ADDR_W    : memory address width
//   DATA_W    : memory data width
//   state_t   : access-stage state (IDLE = nothing in flight, BUSY = driving memory)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int NUM_PORTS = 2;
    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin arbiter with its priority register.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset (priority returns to port 0)
//   i_req  : request vector, bit N = port N
//   o_gnt  : one-hot (or zero) combinational grant vector, forced 0 in reset
// A granted request is always accepted, so priority moves to the other port
// whenever a grant is issued.
// -----------------------------------------------------------------------------
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] i_req,
    output logic [NUM_PORTS-1:0] o_gnt
);

    // r_prio = 0 means port 0 wins a tie, 1 means port 1 wins a tie.
    logic                 r_prio;
    logic [NUM_PORTS-1:0] w_gnt;

    // Grant selection. A lone requester always wins; priority only matters
    // when both ports ask. Grants are held off while reset is asserted so
    // nothing can be accepted until the first edge with rst_n high.
    always_comb begin
        w_gnt = '0;
        if (rst_n) begin
            if (i_req[0] && (!i_req[1] || !r_prio)) begin
                w_gnt[0] = 1'b1;
            end else if (i_req[1]) begin
                w_gnt[1] = 1'b1;
            end
        end
    end

    // Priority hands over to the port that did not just win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (w_gnt[0]) begin
            r_prio <= 1'b1;
        end else if (w_gnt[1]) begin
            r_prio <= 1'b0;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port memory arbiter with a two-stage pipeline: an accept stage that
// arbitrates and latches one request per cycle, and an access stage that
// drives the memory for one cycle and then reports completion.
//   clk, rst_n              : clock, asynchronous active-low reset
//   req0/1, we0/1           : request valid and write enable per port
//   addr0/1, wdata0/1       : request address and write data per port
//   gnt0/1                  : combinational accept (transfer on req & gnt)
//   done0/1                 : one-cycle completion pulse per port
//   rdata0/1                : last read result per port
//   mem_read, mem_write     : memory strobes (access stage)
//   access_addr, write_data : memory address and write data (access stage)
//   read_data               : combinational memory read data
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] access_addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data
);

    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_gnt;
    logic                 w_accept;
    logic                 w_busy;

    state_t r_state;
    state_t w_nextState;

    // Access-stage copy of the accepted request.
    logic              r_port;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              r_done0;
    logic              r_done1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;

    assign w_req = {req1, req0};

    rr_arbiter2 u_rr_arbiter2 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign gnt0     = w_gnt[0];
    assign gnt1     = w_gnt[1];
    assign w_accept = |w_gnt;

    // Access-stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // An accept always fills the access stage for the next cycle, whether or
    // not it is currently busy; without an accept the stage drains.
    always_comb begin
        w_nextState = ST_IDLE;
        case (r_state)
            ST_IDLE: w_nextState = w_accept ? ST_BUSY : ST_IDLE;
            ST_BUSY: w_nextState = w_accept ? ST_BUSY : ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Requester inputs are captured only on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_port  <= w_gnt[1];
            r_we    <= w_gnt[1] ? we1    : we0;
            r_addr  <= w_gnt[1] ? addr1  : addr0;
            r_wdata <= w_gnt[1] ? wdata1 : wdata0;
        end
    end

    // Memory drive comes straight from the state register, so an async
    // reset drops the strobes immediately and an in-flight write never lands.
    assign w_busy      = (r_state == ST_BUSY);
    assign mem_read    = w_busy & ~r_we;
    assign mem_write   = w_busy &  r_we;
    assign access_addr = w_busy ? r_addr  : '0;
    assign write_data  = w_busy ? r_wdata : '0;

    // Completion: the edge ending the access cycle raises done for the
    // owning port and, for reads, captures the memory data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done0  <= 1'b0;
            r_done1  <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_done0 <= w_busy & ~r_port;
            r_done1 <= w_busy &  r_port;
            if (w_busy && !r_we && !r_port) begin
                r_rdata0 <= read_data;
            end
            if (w_busy && !r_we && r_port) begin
                r_rdata1 <= read_data;
            end
        end
    end

    assign done0  = r_done0;
    assign done1  = r_done1;
    assign rdata0 = r_rdata0;
    assign rdata1 = r_rdata1;

endmodule
